passcode_controller: RTL and testbench
======================================

// Module: passcode_controller
// PURPOSE
//  Keypad-entry sequencer for the door-lock passcode datapath (6-cell BCD input/answer
//  register arrays + 6-digit comparator). Steers each keypad digit into the next input
//  cell, requests the compare on '*', and drives unlock/fail/lockout outcomes.
//  Runs the change-passcode flow: verify the current code, then load a new 4-6 digit code.
//  Sits between the keypad decoder (key strobes) and the comparator datapath.
// PARAMETERS
//  MIN_LEN         4         minimum accepted new-passcode length (digits, 1..6)
//  DEF_LEN         6         stored passcode length after reset
//  TIMEOUT_CYCLES  50000000  idle cycles in ENTRY/NEWPW before abandon
//  UNLOCK_CYCLES   100000000 cycles unlocked is held high
//  MAX_FAIL        3         consecutive failures that trigger lockout (LOCKOUT_EN only)
//  LOCKOUT_CYCLES  300000000 lockout duration (LOCKOUT_EN only)
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-high; clears all state
//  key_valid    in   1  one-cycle key strobe from keypad decoder
//  key_code     in   4  0-9 digit, 4'hA '*' (enter), 4'hB '#' (change/cancel); others ignored
//  key_ready    out  1  1 in IDLE/ENTRY/NEWPW; strobes while 0 are dropped
//  digit_data   out  4  BCD digit to the input array (registered copy of key_code)
//  digit_cs     out  6  one-hot input-cell write strobe, 1 cycle, cell = digit_count
//  clear_input  out  1  1-cycle pulse: clear all input cells to 0000
//  compare_req  out  1  1-cycle pulse: datapath evaluates match
//  match        in   1  datapath all-cells-equal; sampled cycle after compare_req
//  answer_load  out  1  1-cycle pulse: parallel-load input cells into answer array
//  answer_len   out  3  stored passcode length, reset DEF_LEN
//  digit_count  out  3  digits entered so far, 0..6
//  unlocked     out  1  door release
//  alarm        out  1  lockout indicator (tied 0 without LOCKOUT_EN)
//  state_dbg    out  3  current FSM state encoding
// BEHAVIOUR
//  Reset: state IDLE; digit_count 0, answer_len DEF_LEN, fail count 0; every pulse output,
//   unlocked, alarm 0; digit_cs 0, digit_data 0. clear_input pulses in first cycle after reset.
//  Digit write (ENTRY/NEWPW, count<6): next cycle digit_data=key, digit_cs[count]=1,
//   count+1. Digit at count==6 is ignored. Any accepted key reloads the timeout.
//  IDLE: digit -> write cell0, chg=0, ENTRY. '#' -> chg=1, ENTRY (count 0). '*' ignored.
//  ENTRY: '*' with count==answer_len -> compare_req, CHECK; '*' otherwise -> FAIL.
//   '#' -> clear_input, IDLE (no fail). Timeout -> clear_input, IDLE (no fail).
//  CHECK (1 cycle after compare_req): match&!chg -> UNLOCK, fail cnt 0;
//   match&chg -> clear_input, NEWPW, count 0, fail cnt 0; !match -> FAIL.
//  UNLOCK: unlocked=1 for exactly UNLOCK_CYCLES; then clear_input, count 0, IDLE.
//  NEWPW: digits as above. '*' with MIN_LEN<=count<=6 -> answer_load, answer_len<=count,
//   then clear_input next cycle, IDLE. '*' with count<MIN_LEN, '#', or timeout ->
//   clear_input, IDLE; answer unchanged.
//  FAIL (1 cycle): clear_input, count 0, fail cnt+1 (saturating); -> LOCKOUT if
//   fail cnt reaches MAX_FAIL, else IDLE.
//  LOCKOUT: alarm=1, keys dropped, LOCKOUT_CYCLES then fail cnt 0, alarm 0, IDLE.
//  Only one key per cycle; key_valid with key_ready=0 is silently dropped.
//  reset mid-operation (any state, incl. UNLOCK/LOCKOUT) -> reset values next cycle;
//   answer_len returns to DEF_LEN (datapath answer array cleared by its own reset).
// CONFIGURATION
//  LOCKOUT_EN defined: fail counter, LOCKOUT state, alarm as above.
//  LOCKOUT_EN undefined: no fail counter, FAIL always -> IDLE, alarm tied 0,
//   MAX_FAIL/LOCKOUT_CYCLES unused.
// STRUCTURE
//  lock_pkg: state encodings (IDLE, ENTRY, CHECK, UNLOCK, NEWPW, FAIL, LOCKOUT),
//   key code constants KEY_STAR=4'hA, KEY_HASH=4'hB, MAX_DIGITS=6.
//  Sub-module cycle_timer: loadable down-counter with done flag, shared for
//   timeout, unlock hold and lockout duration (one instance, reloaded per state).
// TESTING
//  Reset, keys 1,2,3,4,5,6,'*', match=1 -> digit_cs 000001..100000, compare_req, unlocked UNLOCK_CYCLES.
//  '#', old code 6 digits,'*', match=1, then 9,8,7,6,'*' -> answer_load, answer_len=4, IDLE.
//  answer_len=4, keys 1,2,3,'*' -> FAIL, clear_input, no compare_req, count 0.
//  LOCKOUT_EN, MAX_FAIL=3: three mismatches -> alarm=1, keys dropped for LOCKOUT_CYCLES, then IDLE.
//  7 digits entered -> 7th ignored, count=6; no key TIMEOUT_CYCLES -> clear_input, IDLE.
//  reset asserted in UNLOCK and in NEWPW -> unlocked 0, answer_len=6, IDLE next cycle.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared encodings for the door-lock passcode sequencer: FSM states, keypad
// codes and the size of the digit register array.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    UNLOCK  = 3'd3,
    NEWPW   = 3'd4,
    FAIL    = 3'd5,
    LOCKOUT = 3'd6
  } state_t;

  localparam logic [3:0] KEY_STAR   = 4'hA;
  localparam logic [3:0] KEY_HASH   = 4'hB;
  localparam int         MAX_DIGITS = 6;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the entry timeout, unlock hold and lockout
// duration. done is high while the count sits at zero.
module cycle_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins over the decrement; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/passcode_controller.sv
// Keypad-entry sequencer for the door-lock passcode datapath.
// Steers digits into the input cells, requests the compare on '*', handles
// unlock / fail outcomes and the change-passcode flow.
// Optional feature macro: LOCKOUT_EN (fail counter, LOCKOUT state, alarm).
module passcode_controller
  import lock_pkg::*;
#(
  parameter int unsigned MIN_LEN        = 4,
  parameter int unsigned DEF_LEN        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned UNLOCK_CYCLES  = 100000000,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 300000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] digit_data,
  output logic [5:0] digit_cs,
  output logic       clear_input,
  output logic       compare_req,
  input  logic       match,
  output logic       answer_load,
  output logic [2:0] answer_len,
  output logic [2:0] digit_count,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] state_dbg
);

  state_t      state, state_n;
  logic        chg, chg_n;
  logic        clr_pend, pend_n;
  logic [2:0]  cnt_n, len_n;
  logic [3:0]  data_n;
  logic [5:0]  cs_n;
  logic        clr_n, cmp_n, ld_n;
  logic        tmr_load, tmr_done;
  logic [31:0] tmr_val;
  logic        key_acc, key_dig, key_star, key_hash;
  logic        wr, go_idle;

`ifdef LOCKOUT_EN
  logic [7:0]  fail_cnt, fail_n, fail_inc;
`endif

  assign key_ready = (state == IDLE) || (state == ENTRY) || (state == NEWPW);
  assign key_acc   = key_valid && key_ready;
  assign key_dig   = key_acc && is_digit(key_code);
  assign key_star  = key_acc && (key_code == KEY_STAR);
  assign key_hash  = key_acc && (key_code == KEY_HASH);
  assign unlocked  = (state == UNLOCK);
  assign state_dbg = state;

`ifdef LOCKOUT_EN
  assign alarm    = (state == LOCKOUT);
  assign fail_inc = (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
`else
  assign alarm = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_FAIL), 32'(LOCKOUT_CYCLES)};
`endif

  cycle_timer #(.W(32)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state, next-output and timer control; outputs land one cycle later.
  always_comb begin
    state_n  = state;
    chg_n    = chg;
    cnt_n    = digit_count;
    len_n    = answer_len;
    data_n   = digit_data;
    cs_n     = '0;
    clr_n    = clr_pend;   // deferred clear after reset or new-code load
    pend_n   = 1'b0;
    cmp_n    = 1'b0;
    ld_n     = 1'b0;
    wr       = 1'b0;
    go_idle  = 1'b0;
    // every recognised key restarts the inactivity timeout
    tmr_load = key_dig || key_star || key_hash;
    tmr_val  = 32'(TIMEOUT_CYCLES - 1);
`ifdef LOCKOUT_EN
    fail_n   = fail_cnt;
`endif

    unique case (state)
      IDLE: begin
        if (key_dig) begin
          wr      = 1'b1;
          chg_n   = 1'b0;
          state_n = ENTRY;
        end else if (key_hash) begin
          chg_n   = 1'b1;
          cnt_n   = '0;
          state_n = ENTRY;
        end
      end
      ENTRY, NEWPW: begin
        if (key_star) begin
          if (state == ENTRY) begin
            if (digit_count == answer_len) begin
              cmp_n   = 1'b1;
              state_n = CHECK;
            end else begin
              state_n = FAIL;
            end
          end else if (digit_count >= 3'(MIN_LEN)) begin
            ld_n    = 1'b1;
            len_n   = digit_count;
            pend_n  = 1'b1;   // clear the cells only after the load is taken
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            go_idle = 1'b1;
          end
        end else if (key_hash) begin
          go_idle = 1'b1;
        end else if (key_dig) begin
          wr = (digit_count < 3'(MAX_DIGITS));
        end else if (tmr_done) begin
          go_idle = 1'b1;
        end
      end
      CHECK: begin
        // first CHECK cycle carries the request; match is valid the next one
        if (!compare_req) begin
          if (match) begin
`ifdef LOCKOUT_EN
            fail_n = '0;
`endif
            tmr_load = 1'b1;
            if (chg) begin
              clr_n   = 1'b1;
              cnt_n   = '0;
              state_n = NEWPW;
            end else begin
              tmr_val = 32'(UNLOCK_CYCLES - 1);
              state_n = UNLOCK;
            end
          end else begin
            state_n = FAIL;
          end
        end
      end
      UNLOCK: begin
        if (tmr_done) go_idle = 1'b1;
      end
      FAIL: begin
        go_idle = 1'b1;
`ifdef LOCKOUT_EN
        fail_n = fail_inc;
        if (fail_inc >= 8'(MAX_FAIL)) begin
          tmr_load = 1'b1;
          tmr_val  = 32'(LOCKOUT_CYCLES - 1);
        end
`endif
      end
      LOCKOUT: begin
`ifdef LOCKOUT_EN
        if (tmr_done) begin
          fail_n  = '0;
          state_n = IDLE;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase

    if (wr) begin
      data_n = key_code;
      cs_n   = 6'b1 << digit_count;
      cnt_n  = digit_count + 3'd1;
    end
    if (go_idle) begin
      clr_n   = 1'b1;
      cnt_n   = '0;
      state_n = IDLE;
    end
`ifdef LOCKOUT_EN
    if (state == FAIL && fail_inc >= 8'(MAX_FAIL)) state_n = LOCKOUT;
`endif
  end

  // State and registered outputs; reset queues a cell clear for the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      chg         <= 1'b0;
      clr_pend    <= 1'b1;
      digit_count <= '0;
      answer_len  <= 3'(DEF_LEN);
      digit_data  <= '0;
      digit_cs    <= '0;
      clear_input <= 1'b0;
      compare_req <= 1'b0;
      answer_load <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt    <= '0;
`endif
    end else begin
      state       <= state_n;
      chg         <= chg_n;
      clr_pend    <= pend_n;
      digit_count <= cnt_n;
      answer_len  <= len_n;
      digit_data  <= data_n;
      digit_cs    <= cs_n;
      clear_input <= clr_n;
      compare_req <= cmp_n;
      answer_load <= ld_n;
`ifdef LOCKOUT_EN
      fail_cnt    <= fail_n;
`endif
    end
  end

endmodule

// File: tb/tb_passcode_controller.sv
// Directed, table-driven bench for passcode_controller with shortened timers.
module tb_passcode_controller;
  import lock_pkg::*;

  localparam int T = 20;
  localparam int U = 8;
  localparam int L = 10;
`ifdef LOCKOUT_EN
  localparam state_t S3 = LOCKOUT;
`else
  localparam state_t S3 = IDLE;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1, key_valid = 1'b0, match = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_ready, clear_input, compare_req, answer_load, unlocked, alarm;
  logic [3:0] digit_data;
  logic [5:0] digit_cs;
  logic [2:0] answer_len, digit_count, state_dbg;

  always #5 clk = ~clk;

  passcode_controller #(
    .MIN_LEN(4), .DEF_LEN(6), .TIMEOUT_CYCLES(T), .UNLOCK_CYCLES(U),
    .MAX_FAIL(3), .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .digit_data(digit_data), .digit_cs(digit_cs),
    .clear_input(clear_input), .compare_req(compare_req), .match(match),
    .answer_load(answer_load), .answer_len(answer_len), .digit_count(digit_count),
    .unlocked(unlocked), .alarm(alarm), .state_dbg(state_dbg)
  );

  typedef struct {
    logic       rst, kv, m;
    logic [3:0] code;
    state_t     st;
    logic [2:0] cnt, len;
    logic [5:0] cs;
    logic       cmp, clr, ld;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic kv, input int code, input logic m,
                              input state_t st, input int cnt, input logic [5:0] cs,
                              input logic cmp, input logic clr, input logic ld, input int len);
    vec_t v;
    v.rst = rst; v.kv = kv; v.code = 4'(code); v.m = m; v.st = st;
    v.cnt = 3'(cnt); v.cs = cs; v.cmp = cmp; v.clr = clr; v.ld = ld; v.len = 3'(len);
    tbl.push_back(v);
  endfunction

  // digits 1..n typed into st, counting up from zero
  function automatic void add_digits(input int n, input state_t st, input logic m, input int len);
    for (int d = 1; d <= n; d++)
      add(0, 1, d, m, st, d, 6'b1 << (d - 1), 0, 0, 0, len);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int i);
    vec_t v;
    v = tbl[i];
    reset = v.rst; key_valid = v.kv; key_code = v.code; match = v.m;
    tick();
    chk($sformatf("v%0d state", i), 32'(state_dbg), 32'(v.st));
    chk($sformatf("v%0d count", i), 32'(digit_count), 32'(v.cnt));
    chk($sformatf("v%0d cs", i), 32'(digit_cs), 32'(v.cs));
    chk($sformatf("v%0d compare_req", i), 32'(compare_req), 32'(v.cmp));
    chk($sformatf("v%0d clear_input", i), 32'(clear_input), 32'(v.clr));
    chk($sformatf("v%0d answer_load", i), 32'(answer_load), 32'(v.ld));
    chk($sformatf("v%0d answer_len", i), 32'(answer_len), 32'(v.len));
    chk($sformatf("v%0d unlocked", i), 32'(unlocked), 32'(v.st == UNLOCK));
    chk($sformatf("v%0d alarm", i), 32'(alarm), 32'(v.st == LOCKOUT));
    chk($sformatf("v%0d key_ready", i), 32'(key_ready),
        32'(v.st == IDLE || v.st == ENTRY || v.st == NEWPW));
    if (v.cs != 6'd0) chk($sformatf("v%0d digit_data", i), 32'(digit_data), 32'(v.code));
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(i);
    reset = 1'b0; key_valid = 1'b0;
  endtask

  // check the landing cycle after a timed state expires
  task automatic chk_idle_clr(input string name);
    chk({name, " state"}, 32'(state_dbg), 32'(IDLE));
    chk({name, " clear_input"}, 32'(clear_input), 32'd1);
    chk({name, " count"}, 32'(digit_count), 32'd0);
  endtask

  int a0, a1, b1, c1, d1, e1, f1, g1, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // A: reset, six-digit unlock
    a0 = tbl.size();
    add(1, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 6);
    add(1, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 6);
    add(0, 0, 0, 0, IDLE, 0, 0, 0, 1, 0, 6);
    add(0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 6);
    add_digits(6, ENTRY, 1, 6);
    add(0, 1, 10, 1, CHECK, 6, 0, 1, 0, 0, 6);
    add(0, 0, 0, 1, CHECK, 6, 0, 0, 0, 0, 6);
    add(0, 0, 0, 1, UNLOCK, 6, 0, 0, 0, 0, 6);
    a1 = tbl.size();
    // B: change passcode to 9876
    add(0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 6);
    add(0, 1, 11, 1, ENTRY, 0, 0, 0, 0, 0, 6);
    add_digits(6, ENTRY, 1, 6);
    add(0, 1, 10, 1, CHECK, 6, 0, 1, 0, 0, 6);
    add(0, 0, 0, 1, CHECK, 6, 0, 0, 0, 0, 6);
    add(0, 0, 0, 1, NEWPW, 0, 0, 0, 1, 0, 6);
    add(0, 1, 9, 1, NEWPW, 1, 6'b000001, 0, 0, 0, 6);
    add(0, 1, 8, 1, NEWPW, 2, 6'b000010, 0, 0, 0, 6);
    add(0, 1, 7, 1, NEWPW, 3, 6'b000100, 0, 0, 0, 6);
    add(0, 1, 6, 1, NEWPW, 4, 6'b001000, 0, 0, 0, 6);
    add(0, 1, 10, 1, IDLE, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 1, IDLE, 0, 0, 0, 1, 0, 4);
    b1 = tbl.size();
    // C: short entry fail, '#' cancel, two compare mismatches
    add_digits(3, ENTRY, 0, 4);
    add(0, 1, 10, 0, FAIL, 3, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, IDLE, 0, 0, 0, 1, 0, 4);
    add(0, 1, 5, 0, ENTRY, 1, 6'b000001, 0, 0, 0, 4);
    add(0, 1, 11, 0, IDLE, 0, 0, 0, 1, 0, 4);
    add(0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 4);
    for (int k = 0; k < 2; k++) begin
      add_digits(4, ENTRY, 0, 4);
      add(0, 1, 10, 0, CHECK, 4, 0, 1, 0, 0, 4);
      add(0, 0, 0, 0, CHECK, 4, 0, 0, 0, 0, 4);
      add(0, 0, 0, 0, FAIL, 4, 0, 0, 0, 0, 4);
      add(0, 0, 0, 0, (k == 0) ? IDLE : S3, 0, 0, 0, 1, 0, 4);
    end
    c1 = tbl.size();
    // D: seventh digit ignored
    add_digits(6, ENTRY, 0, 4);
    add(0, 1, 7, 0, ENTRY, 6, 0, 0, 0, 0, 4);
    d1 = tbl.size();
    // E: reset while unlocked
    add(0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 4);
    add_digits(4, ENTRY, 1, 4);
    add(0, 1, 10, 1, CHECK, 4, 0, 1, 0, 0, 4);
    add(0, 0, 0, 1, CHECK, 4, 0, 0, 0, 0, 4);
    add(0, 0, 0, 1, UNLOCK, 4, 0, 0, 0, 0, 4);
    add(0, 0, 0, 1, UNLOCK, 4, 0, 0, 0, 0, 4);
    add(1, 0, 0, 1, IDLE, 0, 0, 0, 0, 0, 6);
    add(0, 0, 0, 1, IDLE, 0, 0, 0, 1, 0, 6);
    add(0, 0, 0, 1, IDLE, 0, 0, 0, 0, 0, 6);
    e1 = tbl.size();
    // F: reset while entering a new code
    add(0, 1, 11, 1, ENTRY, 0, 0, 0, 0, 0, 6);
    add_digits(6, ENTRY, 1, 6);
    add(0, 1, 10, 1, CHECK, 6, 0, 1, 0, 0, 6);
    add(0, 0, 0, 1, CHECK, 6, 0, 0, 0, 0, 6);
    add(0, 0, 0, 1, NEWPW, 0, 0, 0, 1, 0, 6);
    add(0, 1, 3, 1, NEWPW, 1, 6'b000001, 0, 0, 0, 6);
    add(1, 0, 0, 1, IDLE, 0, 0, 0, 0, 0, 6);
    add(0, 0, 0, 1, IDLE, 0, 0, 0, 1, 0, 6);
    add(0, 0, 0, 1, IDLE, 0, 0, 0, 0, 0, 6);
    f1 = tbl.size();
    // G: new code shorter than MIN_LEN is rejected
    add(0, 1, 11, 1, ENTRY, 0, 0, 0, 0, 0, 6);
    add_digits(6, ENTRY, 1, 6);
    add(0, 1, 10, 1, CHECK, 6, 0, 1, 0, 0, 6);
    add(0, 0, 0, 1, CHECK, 6, 0, 0, 0, 0, 6);
    add(0, 0, 0, 1, NEWPW, 0, 0, 0, 1, 0, 6);
    add_digits(2, NEWPW, 1, 6);
    add(0, 1, 10, 1, IDLE, 0, 0, 0, 1, 0, 6);
    add(0, 0, 0, 1, IDLE, 0, 0, 0, 0, 0, 6);
    g1 = tbl.size();

    run(a0, a1);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (unlocked) n++;
      else break;
    end
    chk("unlock hold cycles", 32'(n), 32'(U));
    chk_idle_clr("unlock exit");

    run(a1, b1);
    run(b1, c1);
`ifdef LOCKOUT_EN
    n = 1;
    key_valid = 1'b1; key_code = 4'd1;
    for (int k = 0; k < 100; k++) begin
      tick();
      key_valid = 1'b0;
      if (state_dbg == 3'(LOCKOUT)) begin
        n++;
        chk("lockout cs", 32'(digit_cs), 32'd0);
        chk("lockout count", 32'(digit_count), 32'd0);
      end else break;
    end
    chk("lockout cycles", 32'(n), 32'(L));
    chk("lockout exit state", 32'(state_dbg), 32'(IDLE));
    chk("lockout exit alarm", 32'(alarm), 32'd0);
`endif

    run(c1, d1);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (state_dbg == 3'(ENTRY)) n++;
      else break;
    end
    chk("timeout cycles", 32'(n), 32'(T));
    chk_idle_clr("timeout exit");

    run(d1, e1);
    run(e1, f1);
    run(f1, g1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
